// File: rtl/nic_injector_pkg.sv
// Shared entry layout, widths and FSM encoding for the nic_injector slice.
// The optional ejection destination check is enabled with NIC_EJECT_CHECK_EN.
package nic_injector_pkg;

    localparam int BufferBitSize = 22;
    localparam int DstBitSize    = 14;
    localparam int VcBitSize     = 4;

    localparam int FULL   = 21;
    localparam int VC_HI  = 20;
    localparam int VC_LO  = 17;
    localparam int RSVD   = 16;
    localparam int TAIL   = 15;
    localparam int HEAD   = 14;
    localparam int DST_HI = 13;
    localparam int DST_LO = 0;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } nic_state_t;

    typedef logic [BufferBitSize-1:0] entry_t;

    // Builds a full staging entry; the reserved bit is always 0.
    function automatic entry_t make_entry(
        input logic [VcBitSize-1:0]  vc,
        input logic [DstBitSize-1:0] dst,
        input logic                  head,
        input logic                  tail
    );
        entry_t e;
        e                = '0;
        e[FULL]          = 1'b1;
        e[VC_HI:VC_LO]   = vc;
        e[TAIL]          = tail;
        e[HEAD]          = head;
        e[DST_HI:DST_LO] = dst;
        return e;
    endfunction

endpackage

// File: rtl/nic_req_fifo.sv
// Synchronous request FIFO holding {dst, vc, len}; DEPTH must be a power of two.
// Pushes while full and pops while empty are ignored.
module nic_req_fifo #(
    parameter int DATA_W = 22,
    parameter int DEPTH  = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [DATA_W-1:0]        i_data,
    input  logic                     i_pop,
    output logic [DATA_W-1:0]        o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0]   FullCount = DEPTH[PtrW:0];
    localparam logic [PtrW:0]   CntOne    = 1;
    localparam logic [PtrW-1:0] PtrOne    = 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PtrW-1:0]   r_wr_ptr;
    logic [PtrW-1:0]   r_rd_ptr;
    logic [PtrW:0]     r_count;
    logic              w_push;
    logic              w_pop;

    assign o_full  = (r_count == FullCount);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PtrOne;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrOne;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CntOne;
                2'b01:   r_count <= r_count - CntOne;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is deliberately left unreset; only the pointers define validity.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/nic_injector.sv
// Port-0 network interface: segments queued packet requests into flits for the router
// and counts ejected flits/packets. Define NIC_EJECT_CHECK_EN to flag misrouted ejections.
module nic_injector
    import nic_injector_pkg::*;
#(
    parameter int                    NUM_VC  = 4,
    parameter int                    QDEPTH  = 8,
    parameter int                    LEN_W   = 4,
    parameter int                    CNT_W   = 16,
    parameter logic [DstBitSize-1:0] MY_ADDR = '0
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_req_valid,
    output logic                     o_req_ready,
    input  logic [DstBitSize-1:0]    i_req_dst,
    input  logic [VcBitSize-1:0]     i_req_vc,
    input  logic [LEN_W-1:0]         i_req_len,
    input  logic [NUM_VC-1:0]        i_can_inject,
    input  logic                     i_inj_take,
    output logic [BufferBitSize-1:0] o_inj_staging,
    input  logic [BufferBitSize-1:0] i_ej_staging,
    output logic [CNT_W-1:0]         o_ej_flits,
    output logic [CNT_W-1:0]         o_ej_pkts,
    output logic                     o_idle,
    output logic                     o_eject_err
);

    localparam int FifoW = DstBitSize + VcBitSize + LEN_W;
    localparam logic [LEN_W-1:0] LenOne = 1;
    localparam logic [CNT_W-1:0] CntOne = 1;
    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [FifoW-1:0]          w_fifo_wdata;
    logic [FifoW-1:0]          w_fifo_rdata;
    logic                      w_fifo_full;
    logic                      w_fifo_empty;
    logic [$clog2(QDEPTH):0]   w_fifo_count;
    logic [DstBitSize-1:0]     w_pop_dst;
    logic [VcBitSize-1:0]      w_pop_vc;
    logic [LEN_W-1:0]          w_pop_len;

    nic_state_t                r_state;
    nic_state_t                w_next_state;
    logic                      w_pop;
    logic                      w_load;
    logic                      w_slot_free;
    logic                      w_vc_can;
    logic                      w_is_head;
    logic                      w_is_tail;

    logic [DstBitSize-1:0]     r_cur_dst;
    logic [VcBitSize-1:0]      r_cur_vc;
    logic [LEN_W-1:0]          r_cur_len;
    logic [LEN_W-1:0]          r_idx;
    logic [BufferBitSize-1:0]  r_staging;
    logic [CNT_W-1:0]          r_ej_flits;
    logic [CNT_W-1:0]          r_ej_pkts;
    logic                      w_unused;

    assign w_fifo_wdata = {i_req_dst, i_req_vc, i_req_len};
    assign w_pop_dst    = w_fifo_rdata[FifoW-1 -: DstBitSize];
    assign w_pop_vc     = w_fifo_rdata[LEN_W +: VcBitSize];
    assign w_pop_len    = w_fifo_rdata[LEN_W-1:0];

    nic_req_fifo #(
        .DATA_W (FifoW),
        .DEPTH  (QDEPTH)
    ) u_req_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (i_req_valid),
        .i_data  (w_fifo_wdata),
        .i_pop   (w_pop),
        .o_data  (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign o_req_ready = !w_fifo_full;
    assign w_slot_free = !r_staging[FULL] || i_inj_take;
    assign w_is_head   = (r_idx == '0);
    assign w_is_tail   = (r_idx == (r_cur_len - LenOne));

    // VCs beyond NUM_VC never have credit, so a bad vc stalls rather than aliasing.
    always_comb begin
        w_vc_can = 1'b0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (r_cur_vc == VcBitSize'(v)) begin
                w_vc_can = i_can_inject[v];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = SEND;
                end
            end
            SEND: begin
                if (w_slot_free && w_vc_can) begin
                    w_load = 1'b1;
                    if (w_is_tail) begin
                        w_next_state = IDLE;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // A zero-length request is promoted to a single-flit packet at pop time.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cur_dst <= '0;
            r_cur_vc  <= '0;
            r_cur_len <= LenOne;
            r_idx     <= '0;
            r_staging <= '0;
        end else begin
            if (w_pop) begin
                r_cur_dst <= w_pop_dst;
                r_cur_vc  <= w_pop_vc;
                r_cur_len <= (w_pop_len == '0) ? LenOne : w_pop_len;
                r_idx     <= '0;
            end else if (w_load) begin
                r_idx <= r_idx + LenOne;
            end
            if (w_load) begin
                r_staging <= make_entry(r_cur_vc, r_cur_dst, w_is_head, w_is_tail);
            end else if (i_inj_take) begin
                r_staging <= '0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ej_flits <= '0;
            r_ej_pkts  <= '0;
        end else if (i_ej_staging[FULL]) begin
            if (r_ej_flits != CntMax) begin
                r_ej_flits <= r_ej_flits + CntOne;
            end
            if (i_ej_staging[TAIL] && (r_ej_pkts != CntMax)) begin
                r_ej_pkts <= r_ej_pkts + CntOne;
            end
        end
    end

`ifdef NIC_EJECT_CHECK_EN
    logic r_eject_err;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_eject_err <= 1'b0;
        end else if (i_ej_staging[FULL] && (i_ej_staging[DST_HI:DST_LO] != MY_ADDR)) begin
            r_eject_err <= 1'b1;
        end
    end

    assign o_eject_err = r_eject_err;
    assign w_unused    = ^{i_ej_staging[VC_HI:RSVD], i_ej_staging[HEAD], w_fifo_count};
`else
    assign o_eject_err = 1'b0;
    assign w_unused    = ^{i_ej_staging[VC_HI:RSVD], i_ej_staging[HEAD:DST_LO], MY_ADDR, w_fifo_count};
`endif

    assign o_inj_staging = r_staging;
    assign o_ej_flits    = r_ej_flits;
    assign o_ej_pkts     = r_ej_pkts;
    assign o_idle        = w_fifo_empty && (r_state == IDLE) && !r_staging[FULL];

endmodule

// File: tb/tb_nic_injector.sv
// Scoreboard bench for nic_injector: requests queue expected staging entries that a
// negedge monitor consumes; ejection counters and reset state are checked directly.
`timescale 1ns/1ps
module tb_nic_injector;

    localparam int TbCntW = 4;

`ifdef NIC_EJECT_CHECK_EN
    localparam logic ExpErr = 1'b1;
`else
    localparam logic ExpErr = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rstN;
    logic              reqValid;
    logic              reqReady;
    logic [13:0]       reqDst;
    logic [3:0]        reqVc;
    logic [3:0]        reqLen;
    logic [3:0]        canInject;
    logic              injTake;
    logic [21:0]       injStaging;
    logic [21:0]       ejStaging;
    logic [TbCntW-1:0] ejFlits;
    logic [TbCntW-1:0] ejPkts;
    logic              idle;
    logic              ejectErr;

    logic [21:0]       expQ [$];
    logic [21:0]       monWant;
    int                checks = 0;
    int                errors = 0;

    nic_injector #(
        .NUM_VC  (4),
        .QDEPTH  (8),
        .LEN_W   (4),
        .CNT_W   (TbCntW),
        .MY_ADDR (14'd0)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rstN),
        .i_req_valid   (reqValid),
        .o_req_ready   (reqReady),
        .i_req_dst     (reqDst),
        .i_req_vc      (reqVc),
        .i_req_len     (reqLen),
        .i_can_inject  (canInject),
        .i_inj_take    (injTake),
        .o_inj_staging (injStaging),
        .i_ej_staging  (ejStaging),
        .o_ej_flits    (ejFlits),
        .o_ej_pkts     (ejPkts),
        .o_idle        (idle),
        .o_eject_err   (ejectErr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Every flit the router takes must be the next one the bench predicted.
    always @(negedge clk) begin
        if (injTake && injStaging[21]) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL inj_flit: got %h, required no flit", injStaging);
            end else begin
                monWant = expQ.pop_front();
                if (injStaging !== monWant) begin
                    errors++;
                    $display("[TB] FAIL inj_flit: got %h, required %h", injStaging, monWant);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
        end
    endtask

    // Called just after a rising edge; presents one request for exactly one edge.
    task automatic applyStimulus(input logic [13:0] dst, input logic [3:0] vc,
                                 input logic [3:0] len, input logic expectAccept);
        int effLen;
        reqValid = 1'b1;
        reqDst   = dst;
        reqVc    = vc;
        reqLen   = len;
        checkOutput("req_ready", 32'(reqReady), 32'(expectAccept));
        @(posedge clk);
        #1;
        reqValid = 1'b0;
        if (expectAccept) begin
            effLen = (len == 4'd0) ? 1 : int'(len);
            for (int i = 0; i < effLen; i++) begin
                expQ.push_back({1'b1, vc, 1'b0, (i == effLen - 1), (i == 0), dst});
            end
        end
    endtask

    task automatic waitDrain(input string name, input int maxCycles);
        int n;
        n = 0;
        while ((expQ.size() != 0 || !idle) && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, {30'b0, (expQ.size() == 0), idle}, 32'h3);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstN      = 1'b0;
        reqValid  = 1'b0;
        reqDst    = '0;
        reqVc     = '0;
        reqLen    = '0;
        canInject = 4'hF;
        injTake   = 1'b1;
        ejStaging = '0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_staging", 32'(injStaging), 32'h0);
        checkOutput("rst_ready", 32'(reqReady), 32'h1);
        checkOutput("rst_idle", 32'(idle), 32'h1);
        checkOutput("rst_flits", 32'(ejFlits), 32'h0);
        checkOutput("rst_pkts", 32'(ejPkts), 32'h0);
        checkOutput("rst_err", 32'(ejectErr), 32'h0);
        rstN = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] single-flit packet");
        applyStimulus(14'd12, 4'd1, 4'd1, 1'b1);
        @(negedge clk);
        checkOutput("t1_lat0", 32'(injStaging), 32'h0);
        @(negedge clk);
        checkOutput("t1_lat1", 32'(injStaging), 32'h0);
        @(negedge clk);
        checkOutput("t1_entry", 32'(injStaging), 32'h22C00C);
        waitDrain("t1_drain", 20);
        checkOutput("t1_cleared", 32'(injStaging), 32'h0);

        $display("[TB] three-flit packet");
        applyStimulus(14'd5, 4'd2, 4'd3, 1'b1);
        waitDrain("t2_drain", 20);

        $display("[TB] blocked vc");
        canInject = 4'b0111;
        applyStimulus(14'd33, 4'd3, 4'd2, 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput("t3_blocked", 32'(injStaging), 32'h0);
        end
        checkOutput("t3_busy", 32'(idle), 32'h0);
        @(posedge clk);
        #1;
        canInject = 4'hF;
        waitDrain("t3_drain", 20);

        $display("[TB] fifo full");
        canInject = 4'h0;
        applyStimulus(14'd100, 4'd0, 4'd1, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 9; k++) begin
            applyStimulus(14'(200 + k), 4'(k % 4), (k % 2 == 1) ? 4'd0 : 4'd1, (k < 8));
        end
        checkOutput("t4_full", 32'(reqReady), 32'h0);
        canInject = 4'hF;
        waitDrain("t4_drain", 100);
        checkOutput("t4_ready", 32'(reqReady), 32'h1);

        $display("[TB] ejection counters");
        ejStaging = {1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 14'd0};
        @(posedge clk);
        #1;
        ejStaging = {1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 14'd0};
        @(posedge clk);
        #1;
        ejStaging = {1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 14'd0};
        @(posedge clk);
        #1;
        ejStaging = {1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 14'd0};
        @(posedge clk);
        #1;
        ejStaging = '0;
        @(negedge clk);
        checkOutput("t5_flits", 32'(ejFlits), 32'd4);
        checkOutput("t5_pkts", 32'(ejPkts), 32'd2);
        checkOutput("t5_err_clean", 32'(ejectErr), 32'h0);
        @(posedge clk);
        #1;
        ejStaging = {1'b1, 4'd1, 1'b0, 1'b1, 1'b0, 14'd7};
        repeat (14) @(posedge clk);
        #1;
        ejStaging = '0;
        @(negedge clk);
        checkOutput("t5_flits_sat", 32'(ejFlits), 32'd15);
        checkOutput("t5_pkts_sat", 32'(ejPkts), 32'd15);
        checkOutput("t5_err", 32'(ejectErr), 32'(ExpErr));
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t5_err_sticky", 32'(ejectErr), 32'(ExpErr));

        $display("[TB] reset mid-packet");
        applyStimulus(14'd21, 4'd1, 4'd3, 1'b1);
        begin
            int n;
            n = 0;
            while (n < 20) begin
                @(posedge clk);
                #2;
                n++;
                if (injStaging[21]) break;
            end
            checkOutput("t6_first_flit", 32'(injStaging[21]), 32'h1);
        end
        rstN = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("t6_staging", 32'(injStaging), 32'h0);
        checkOutput("t6_ready", 32'(reqReady), 32'h1);
        checkOutput("t6_idle", 32'(idle), 32'h1);
        checkOutput("t6_flits", 32'(ejFlits), 32'h0);
        checkOutput("t6_pkts", 32'(ejPkts), 32'h0);
        checkOutput("t6_err", 32'(ejectErr), 32'h0);
        checkOutput("t6_dropped", 32'(expQ.size()), 32'd2);
        expQ.delete();
        rstN = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(14'd9, 4'd0, 4'd2, 1'b1);
        waitDrain("t6_drain", 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nic_injector.md
Name: nic_injector

Overview:
- Network-interface block on router port 0, the local injection/ejection port.
- Upstream side: accepts packet requests (dst, vc, length) into a request FIFO and segments each packet into flits.
- Drives the router's port-0 input staging slot, gated per VC by the router's can_inject.
- Downstream side: consumes the router's port-0 output staging slot and counts delivered flits and packets.

Parameters:
- NUM_VC, 4, number of virtual channels; width of can_inject.
- QDEPTH, 8, request FIFO depth; power of two, at least 2.
- LEN_W, 4, packet-length field width.
- CNT_W, 16, ejection counter width.
- MY_ADDR, 0, this node's 14-bit address; used only with NIC_EJECT_CHECK_EN.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  packet request valid
- req_ready  out  1  FIFO not full
- req_dst  in  14  destination address
- req_vc  in  4  virtual channel
- req_len  in  LEN_W  flits per packet; 0 is treated as 1
- can_inject  in  NUM_VC  router port-0 buffer free, per VC
- inj_take  in  1  router sampling staging this cycle (LoadStaging op)
- inj_staging  out  22  staging entry to router slot 0
- ej_staging  in  22  router port-0 output staging entry
- ej_flits  out  CNT_W  flits ejected
- ej_pkts  out  CNT_W  tail flits ejected
- idle  out  1  FIFO empty, FSM IDLE, staging empty
- eject_err  out  1  sticky destination mismatch (feature only)

Behaviour:
- Staging entry layout, 22 bits, package constants:
  - [21] full
  - [20:17] vc
  - [16] reserved, driven 0
  - [15] tail
  - [14] head
  - [13:0] dst
- Reset: clocked while rst_n=0. Result:
  - FIFO empty, req_ready=1.
  - FSM IDLE.
  - inj_staging=0, counters=0, eject_err=0, idle=1.
  - Reset mid-packet drops the packet with no partial flush.
- Request FIFO:
  - Push when req_valid && req_ready.
  - req_ready = !full, registered count; a push in a full cycle is ignored.
  - Simultaneous push and pop while full is not allowed because ready=0.
  - Pointers wrap mod QDEPTH.
- FSM IDLE:
  - If FIFO not empty: pop into cur_dst/cur_vc/cur_len with len 0 mapped to 1, idx=0, go SEND. Latency is one cycle.
  - Otherwise stay in IDLE.
- FSM SEND:
  - Staging slot is free when inj_staging[21]==0 or inj_take==1 this cycle.
  - Load a flit when the slot is free and can_inject[cur_vc]==1:
    - full=1, vc=cur_vc, dst=cur_dst
    - head=(idx==0), tail=(idx==cur_len-1)
    - idx++
  - Loading the tail flit returns the FSM to IDLE; the next pop happens at the earliest on the following cycle.
  - If inj_take && !load: inj_staging <= 0.
  - If the slot is not free or can_inject is low: hold, no flit is lost or duplicated.
  - Single-flit packet: head=tail=1.
  - can_inject is sampled only at load time; deassertion while a flit sits in staging does not retract it.
- Ejection, every cycle ej_staging[21]==1:
  - ej_flits++.
  - If ej_staging[15] is set: ej_pkts++.
  - Both counters saturate at all-ones, with no wrap.
- idle: combinational AND of FIFO empty, FSM IDLE and !inj_staging[21].

Optional Feature:
- NIC_EJECT_CHECK_EN defined:
  - An ejected full entry with dst != MY_ADDR sets eject_err, sticky until reset.
  - The flit is still counted.
- Not defined: eject_err tied 0 and no comparator is built.

Decomposition:
- Shared package/include holds:
  - entry field ranges: FULL, VC, TAIL, HEAD, DST
  - BufferBitSize=22, DstBitSize=14, VcBitSize=4
  - FSM state encodings IDLE/SEND
- The existing parameters include gains only the new macros.
- One sub-module, nic_req_fifo: parameterised sync FIFO holding {dst,vc,len}, with full/empty/count.

Test Plan:
- Reset, then one request dst=12 vc=1 len=1, can_inject=all-ones, inj_take asserted each cycle -> inj_staging = {1,4'd1,0,1,1,14'd12} two cycles after push, then 0; idle returns to 1.
- len=3 dst=5 vc=2 -> three consecutive entries with head/tail bits 1/0, 0/0, 0/1; FSM back in IDLE after the third.
- len=2 vc=3 with can_inject[3]=0 for 5 cycles, then 1 -> staging stays 0 while blocked; both flits follow in order, no duplicates.
- Push 9 requests with QDEPTH=8 and FSM stalled (can_inject=0) -> req_ready drops after the 8th and the 9th is rejected; releasing can_inject drains all 8 in order.
- ej_staging with full=1 for 4 cycles, tail set on the 2nd and 4th -> ej_flits=4, ej_pkts=2; preload near all-ones confirms saturation; with NIC_EJECT_CHECK_EN and dst!=MY_ADDR, eject_err=1 and it stays set.
- Assert rst_n=0 mid-packet (idx=1 of 3) -> next cycle staging=0, FIFO empty, counters 0; the following request is processed normally.
